ysyx_040066_trap_ctrl: RTL
==========================

# ysyx_040066_trap_ctrl

Machine-mode trap and interrupt controller for the ysyx_040066 core. It sits directly downstream of the CLINT timer block and consumes that block's level `intr` output. It holds the M-mode trap CSRs. At the commit boundary it decides between ecall, mret and timer interrupt, and drives a registered, handshaked redirect and flush to the front end.

## Interface
Parameters:
- RESET_MTVEC, 64'h0, reset value of mtvec. Low 2 bits are forced to 0 (direct mode only).

Ports:
- clk  in  1  core clock. Everything is sampled on posedge.
- rst  in  1  synchronous, active-high reset
- timer_irq  in  1  level timer interrupt from the CLINT `intr` output
- commit_valid  in  1  one instruction commits this cycle
- commit_pc  in  64  PC of the committing instruction
- commit_next_pc  in  64  architectural next PC of the committing instruction
- commit_ecall  in  1  committing instruction is ecall (qualified by commit_valid)
- commit_mret  in  1  committing instruction is mret (qualified by commit_valid)
- csr_wen  in  1  CSR write by the committing instruction (qualified by commit_valid)
- csr_waddr  in  12  CSR write address
- csr_wdata  in  64  CSR write data, full value
- csr_raddr  in  12  CSR read address
- csr_rdata  out  64  combinational read data
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  64  redirect target
- redirect_ready  in  1  fetch accepts redirect
- flush  out  1  kill all in-flight instructions. Equal to redirect_valid.
- irq_pending  out  1  mip.MTIP & mie.MTIE & mstatus.MIE (debug/visibility)

## Operation
- CSRs: mstatus 0x300 (only MIE[3], MPIE[7], MPP[12:11] implemented; MPP reads 2'b11), mie 0x304 (only MTIE[7]), mtvec 0x305, mscratch 0x340, mepc 0x341 (bits [1:0] read 0), mcause 0x342, mip 0x344 (only MTIP[7], read-only).
- Unimplemented addresses and bits read 0. Writes to them are ignored.
- mip.MTIP is a register: it takes timer_irq every cycle, giving one cycle of latency.
- The state machine has two states, RUN and REDIRECT.
- RUN: trap evaluation happens only when commit_valid=1. Priority, highest first:
  - commit_ecall: mepc<=commit_pc; mcause<=64'd11; target mtvec.
  - commit_mret: MIE<=MPIE; MPIE<=1; target mepc. No mcause/mepc update.
  - irq_pending: mepc<=commit_next_pc; mcause<=64'h8000_0000_0000_0007; target mtvec.
- On an ecall or interrupt trap: MPIE<=MIE; MIE<=0.
- Taking any of the three: load redirect_pc with the target, set redirect_valid=1, go to REDIRECT.
- No trap: stay in RUN. csr_wen updates the addressed CSR.
- A CSR write and a trap in the same commit: the write is applied first, then the trap updates override any fields they touch.
- The trap target uses the mtvec value before that cycle's write.
- Example: an interrupt taken on a commit that writes mstatus.MIE=1 ends with MIE=0 and MPIE=1.
- An interrupt is never taken when there is no commit. A pending interrupt waits for the next commit_valid.
- REDIRECT: redirect_valid and flush are held at 1 and redirect_pc is held stable.
  - commit_valid and csr_wen are ignored, with no CSR update. The pipeline guarantees no commits here.
  - The state is left on the cycle redirect_valid & redirect_ready = 1. The next state is RUN and redirect_valid goes to 0.
- Reset values:
  - mstatus fields MIE=0, MPIE=0; mie=0; mip=0; mtvec=RESET_MTVEC&~3; mscratch=0; mepc=0; mcause=0.
  - State RUN; redirect_valid=0; flush=0; redirect_pc=0; irq_pending=0.

## Timing
- Commit in cycle N causes a trap. CSR updates take effect at the posedge ending N. redirect_valid=1 from cycle N+1.
- Redirect latency is 1 cycle minimum. If redirect_ready=1 in N+1, the state is back in RUN at N+2.
- The commit arriving in the first RUN cycle is evaluated.
- A timer_irq rise in cycle N shows in mip/irq_pending from N+1. With MIE/MTIE set, the first commit at or after N+1 traps.
- rst takes priority over everything. rst during REDIRECT returns to RUN with all outputs at reset values in the next cycle.
- csr_rdata reflects register state only, not same-cycle writes: write-then-read shows the new value one cycle later.
- A level timer_irq that stays high after mret with MIE=1 retraps on the next commit.

## Test plan
- Reset: set rst=1 for 2 cycles. Then mtvec=RESET_MTVEC&~3, mstatus reads 64'h1800, and redirect_valid=0, flush=0, irq_pending=0.
- ecall: mtvec=0x8000_0100, commit ecall at pc 0x8000_0010. In N+1, redirect_pc=0x8000_0100 and flush=1. Then mepc=0x8000_0010 and mcause=11. MIE=1 before gives MIE=0, MPIE=1.
- Timer interrupt:
  - Setup: MIE=1, MTIE=1; raise timer_irq; commit pc 0x8000_0020 with next 0x8000_0024.
  - Result: mepc=0x8000_0024, mcause=0x8000_0000_0000_0007, redirect to mtvec.
  - Same setup with MIE=0: no trap; irq_pending=0.
- Handshake: hold redirect_ready=0 for 3 cycles after a trap. redirect_valid and redirect_pc stay stable, and commits plus csr_wen during those cycles change no CSR. Assert ready: exit next cycle.
- mret: mepc=0x8000_0040, MPIE=1, MIE=0; commit mret. Then redirect_pc=0x8000_0040, MIE=1, MPIE=1.
- Simultaneous events:
  - ecall commit with timer pending: ecall wins, mcause=11.
  - CSR write of mtvec=0x9000_0000 on an interrupt commit: the target is the old mtvec, and mtvec reads 0x9000_0000 afterwards.
  - rst asserted during REDIRECT: redirect_valid=0 next cycle.

Source files
------------

// File: rtl/ysyx_040066_trap_ctrl.sv
// rtl/ysyx_040066_trap_ctrl.sv - M-mode trap CSRs and commit-boundary trap/redirect control
//
// Purpose: holds the machine-mode trap CSRs (mstatus, mie, mtvec, mscratch,
// mepc, mcause, mip). At each commit it picks ecall, mret or a pending timer
// interrupt, in that order. It then drives a registered redirect/flush to
// fetch and holds it until fetch accepts it.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   timer_irq                  level timer interrupt from the CLINT
//   commit_*                   committing instruction info (qualified by commit_valid)
//   csr_wen/waddr/wdata        CSR write by the committing instruction
//   csr_raddr/csr_rdata        combinational CSR read port (register state only)
//   redirect_valid/pc/ready    redirect handshake to fetch
//   flush                      kill in-flight instructions (same as redirect_valid)
//   irq_pending                MTIP & MTIE & MIE
module ysyx_040066_trap_ctrl #(
    parameter logic [63:0] RESET_MTVEC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_irq,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [63:0] commit_next_pc,
    input  logic        commit_ecall,
    input  logic        commit_mret,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [63:0] csr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [63:0] csr_rdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
    localparam logic [63:0] MTVEC_RESET   = {RESET_MTVEC[63:2], 2'b00};

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mip_mtip_q;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    logic        take_trap;
    logic [63:0] trap_target;
    logic [63:0] mepc_rd;

    // mepc keeps the full written value but always presents bits [1:0] as 0,
    // both on reads and as the mret target.
    assign mepc_rd     = {mepc_q[63:2], 2'b00};
    assign irq_pending = mip_mtip_q & mie_mtie_q & mstatus_mie_q;

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = redirect_valid_q;

    // Read port: MPP is hardwired to M-mode (2'b11).
    always_comb begin
        csr_rdata = 64'h0;
        case (csr_raddr)
            ADDR_MSTATUS:  csr_rdata = {51'h0, 2'b11, 3'b000, mstatus_mpie_q, 3'b000,
                                        mstatus_mie_q, 3'b000};
            ADDR_MIE:      csr_rdata = {56'h0, mie_mtie_q, 7'h0};
            ADDR_MTVEC:    csr_rdata = mtvec_q;
            ADDR_MSCRATCH: csr_rdata = mscratch_q;
            ADDR_MEPC:     csr_rdata = mepc_rd;
            ADDR_MCAUSE:   csr_rdata = mcause_q;
            ADDR_MIP:      csr_rdata = {56'h0, mip_mtip_q, 7'h0};
            default:       csr_rdata = 64'h0;
        endcase
    end

    // Next-state logic. Within a commit the CSR write is applied first and
    // the trap side effects are layered on top, so a trap reads the
    // post-write mstatus fields. Targets come from the pre-write registers.
    always_comb begin
        state_d          = state_q;
        mstatus_mie_d    = mstatus_mie_q;
        mstatus_mpie_d   = mstatus_mpie_q;
        mie_mtie_d       = mie_mtie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        take_trap        = 1'b0;
        trap_target      = 64'h0;

        unique case (state_q)
            ST_RUN: begin
                if (commit_valid) begin
                    if (csr_wen) begin
                        case (csr_waddr)
                            ADDR_MSTATUS: begin
                                mstatus_mie_d  = csr_wdata[3];
                                mstatus_mpie_d = csr_wdata[7];
                            end
                            ADDR_MIE:      mie_mtie_d = csr_wdata[7];
                            ADDR_MTVEC:    mtvec_d    = {csr_wdata[63:2], 2'b00};
                            ADDR_MSCRATCH: mscratch_d = csr_wdata;
                            ADDR_MEPC:     mepc_d     = csr_wdata;
                            ADDR_MCAUSE:   mcause_d   = csr_wdata;
                            default: ;
                        endcase
                    end

                    if (commit_ecall) begin
                        take_trap      = 1'b1;
                        trap_target    = mtvec_q;
                        mepc_d         = commit_pc;
                        mcause_d       = CAUSE_ECALL_M;
                        mstatus_mpie_d = mstatus_mie_d;
                        mstatus_mie_d  = 1'b0;
                    end else if (commit_mret) begin
                        take_trap      = 1'b1;
                        trap_target    = mepc_rd;
                        mstatus_mie_d  = mstatus_mpie_d;
                        mstatus_mpie_d = 1'b1;
                    end else if (irq_pending) begin
                        take_trap      = 1'b1;
                        trap_target    = mtvec_q;
                        mepc_d         = commit_next_pc;
                        mcause_d       = CAUSE_MTI;
                        mstatus_mpie_d = mstatus_mie_d;
                        mstatus_mie_d  = 1'b0;
                    end

                    if (take_trap) begin
                        state_d          = ST_REDIRECT;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = trap_target;
                    end
                end
            end
            ST_REDIRECT: begin
                // Commits cannot occur here; any that appear are dropped.
                if (redirect_ready) begin
                    state_d          = ST_RUN;
                    redirect_valid_d = 1'b0;
                end
            end
            default: begin
                state_d          = ST_RUN;
                redirect_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            mie_mtie_q       <= 1'b0;
            mip_mtip_q       <= 1'b0;
            mtvec_q          <= MTVEC_RESET;
            mscratch_q       <= 64'h0;
            mepc_q           <= 64'h0;
            mcause_q         <= 64'h0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'h0;
        end else begin
            state_q          <= state_d;
            mstatus_mie_q    <= mstatus_mie_d;
            mstatus_mpie_q   <= mstatus_mpie_d;
            mie_mtie_q       <= mie_mtie_d;
            mip_mtip_q       <= timer_irq;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule
